l1_l2_request_scheduler: RTL and testbench

L1_L2_REQUEST_SCHEDULER -- requirements
Module: l1_l2_request_scheduler

---
 rtl/l1_l2_request_scheduler.sv | 175 +++++++++++++++++
 tb/tb_l1_l2_request_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_request_scheduler.sv
// Round-robin scheduler that merges dcache, icache and store-queue misses into one
// registered L2 request slot. Issue is limited by a credit counter of in-flight requests.
module l1_l2_request_scheduler #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        dd_dequeue_ready,
    input  logic [25:0] dd_dequeue_addr,
    input  logic [1:0]  dd_dequeue_idx,
    input  logic        dd_dequeue_sync,
    output logic        dd_dequeue_ack,

    input  logic        ic_dequeue_ready,
    input  logic [25:0] ic_dequeue_addr,
    input  logic [1:0]  ic_dequeue_idx,
    output logic        ic_dequeue_ack,

    input  logic        sq_dequeue_ready,
    input  logic [25:0] sq_dequeue_addr,
    input  logic [1:0]  sq_dequeue_idx,
    output logic        sq_dequeue_ack,

    output logic        l2_request_valid,
    output logic [1:0]  l2_request_type,
    output logic [25:0] l2_request_addr,
    output logic [1:0]  l2_request_idx,
    output logic        l2_request_sync,
    input  logic        l2_request_ready,

    input  logic        l2_response_valid
);

    // Round-robin priority pointer:
    //   state  | meaning
    //   PTR_DD | dcache is checked first, then icache, then store queue
    //   PTR_IC | icache is checked first, then store queue, then dcache
    //   PTR_SQ | store queue is checked first, then dcache, then icache

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTSTANDING);

    localparam logic [1:0] TYPE_DD = 2'd0;
    localparam logic [1:0] TYPE_IC = 2'd1;
    localparam logic [1:0] TYPE_SQ = 2'd2;

    typedef enum logic [1:0] {
        PTR_DD = 2'd0,
        PTR_IC = 2'd1,
        PTR_SQ = 2'd2
    } ptr_t;

    ptr_t            ptr_q;
    ptr_t            ptr_d;
    logic [2:0]      src_ready;
    logic [2:0]      pick;
    logic [2:0]      gnt;
    logic            grant;
    logic            can_load;
    logic [CW-1:0]   credit_count;

    logic [1:0]      type_d;
    logic [25:0]     addr_d;
    logic [1:0]      idx_d;
    logic            sync_d;

    assign src_ready = {sq_dequeue_ready, ic_dequeue_ready, dd_dequeue_ready};
    assign can_load  = !l2_request_valid || l2_request_ready;

    // First ready source at or after the pointer; bit order is {sq, ic, dd}.
    always_comb begin
        pick = 3'b000;
        case (ptr_q)
            PTR_DD: begin
                if (src_ready[0])      pick = 3'b001;
                else if (src_ready[1]) pick = 3'b010;
                else if (src_ready[2]) pick = 3'b100;
            end
            PTR_IC: begin
                if (src_ready[1])      pick = 3'b010;
                else if (src_ready[2]) pick = 3'b100;
                else if (src_ready[0]) pick = 3'b001;
            end
            PTR_SQ: begin
                if (src_ready[2])      pick = 3'b100;
                else if (src_ready[0]) pick = 3'b001;
                else if (src_ready[1]) pick = 3'b010;
            end
            default: pick = 3'b000;
        endcase
    end

    // Reset gates the grant so acks stay low while reset is held.
    assign gnt   = (!reset && can_load && (credit_count != '0)) ? pick : 3'b000;
    assign grant = |gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= PTR_DD;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) ptr_d = PTR_IC;
        if (gnt[1]) ptr_d = PTR_SQ;
        if (gnt[2]) ptr_d = PTR_DD;
    end

    always_comb begin
        dd_dequeue_ack = gnt[0];
        ic_dequeue_ack = gnt[1];
        sq_dequeue_ack = gnt[2];
    end

    always_comb begin
        type_d = TYPE_DD;
        addr_d = dd_dequeue_addr;
        idx_d  = dd_dequeue_idx;
        sync_d = dd_dequeue_sync;
        if (gnt[1]) begin
            type_d = TYPE_IC;
            addr_d = ic_dequeue_addr;
            idx_d  = ic_dequeue_idx;
            sync_d = 1'b0;
        end else if (gnt[2]) begin
            type_d = TYPE_SQ;
            addr_d = sq_dequeue_addr;
            idx_d  = sq_dequeue_idx;
            sync_d = 1'b0;
        end
    end

    // Single output slot: load on grant, drain when accepted with nothing new, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2_request_valid <= 1'b0;
            l2_request_type  <= 2'd0;
            l2_request_addr  <= 26'd0;
            l2_request_idx   <= 2'd0;
            l2_request_sync  <= 1'b0;
        end else if (grant) begin
            l2_request_valid <= 1'b1;
            l2_request_type  <= type_d;
            l2_request_addr  <= addr_d;
            l2_request_idx   <= idx_d;
            l2_request_sync  <= sync_d;
        end else if (can_load) begin
            l2_request_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_count <= CREDIT_MAX;
        end else begin
            case ({grant, l2_response_valid})
                2'b10:   credit_count <= credit_count - CW'(1);
                2'b01:   credit_count <= credit_count + CW'(1);
                default: credit_count <= credit_count;
            endcase
        end
    end

    // A credit return with every credit already home means L2 answered a request never sent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(l2_response_valid && (credit_count == CREDIT_MAX)));
        end
    end

endmodule

// File: tb/tb_l1_l2_request_scheduler.sv
// Directed bench for l1_l2_request_scheduler: arbitration order, credit limits,
// backpressure hold and asynchronous reset behaviour.
module tb_l1_l2_request_scheduler;

    logic        clk;
    logic        reset;
    logic        dd_dequeue_ready;
    logic [25:0] dd_dequeue_addr;
    logic [1:0]  dd_dequeue_idx;
    logic        dd_dequeue_sync;
    logic        dd_dequeue_ack;
    logic        ic_dequeue_ready;
    logic [25:0] ic_dequeue_addr;
    logic [1:0]  ic_dequeue_idx;
    logic        ic_dequeue_ack;
    logic        sq_dequeue_ready;
    logic [25:0] sq_dequeue_addr;
    logic [1:0]  sq_dequeue_idx;
    logic        sq_dequeue_ack;
    logic        l2_request_valid;
    logic [1:0]  l2_request_type;
    logic [25:0] l2_request_addr;
    logic [1:0]  l2_request_idx;
    logic        l2_request_sync;
    logic        l2_request_ready;
    logic        l2_response_valid;

    logic [2:0]  acks;
    int          total;
    int          bad;

    assign acks = {sq_dequeue_ack, ic_dequeue_ack, dd_dequeue_ack};

    l1_l2_request_scheduler #(.MAX_OUTSTANDING(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .dd_dequeue_ready  (dd_dequeue_ready),
        .dd_dequeue_addr   (dd_dequeue_addr),
        .dd_dequeue_idx    (dd_dequeue_idx),
        .dd_dequeue_sync   (dd_dequeue_sync),
        .dd_dequeue_ack    (dd_dequeue_ack),
        .ic_dequeue_ready  (ic_dequeue_ready),
        .ic_dequeue_addr   (ic_dequeue_addr),
        .ic_dequeue_idx    (ic_dequeue_idx),
        .ic_dequeue_ack    (ic_dequeue_ack),
        .sq_dequeue_ready  (sq_dequeue_ready),
        .sq_dequeue_addr   (sq_dequeue_addr),
        .sq_dequeue_idx    (sq_dequeue_idx),
        .sq_dequeue_ack    (sq_dequeue_ack),
        .l2_request_valid  (l2_request_valid),
        .l2_request_type   (l2_request_type),
        .l2_request_addr   (l2_request_addr),
        .l2_request_idx    (l2_request_idx),
        .l2_request_sync   (l2_request_sync),
        .l2_request_ready  (l2_request_ready),
        .l2_response_valid (l2_response_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dd_dequeue_ready  = 1'b0;
        dd_dequeue_addr   = '0;
        dd_dequeue_idx    = '0;
        dd_dequeue_sync   = 1'b0;
        ic_dequeue_ready  = 1'b0;
        ic_dequeue_addr   = '0;
        ic_dequeue_idx    = '0;
        sq_dequeue_ready  = 1'b0;
        sq_dequeue_addr   = '0;
        sq_dequeue_idx    = '0;
        l2_request_ready  = 1'b0;
        l2_response_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();

        // reset state, acks held low even with a ready source
        dd_dequeue_ready = 1'b1;
        #1;
        chk("rst_acks", {29'd0, acks}, 32'd0);
        chk("rst_valid", {31'd0, l2_request_valid}, 32'd0);
        chk("rst_type", {30'd0, l2_request_type}, 32'd0);
        chk("rst_addr", {6'd0, l2_request_addr}, 32'd0);
        chk("rst_idx", {30'd0, l2_request_idx}, 32'd0);
        chk("rst_sync", {31'd0, l2_request_sync}, 32'd0);
        chk("rst_credit", 32'(dut.credit_count), 32'd8);

        // single dcache request
        do_reset();
        dd_dequeue_ready = 1'b1;
        dd_dequeue_addr  = 26'h123;
        dd_dequeue_idx   = 2'd2;
        dd_dequeue_sync  = 1'b1;
        l2_request_ready = 1'b1;
        #1;
        chk("t1_ack", {29'd0, acks}, 32'b001);
        tick();
        dd_dequeue_ready = 1'b0;
        chk("t1_valid", {31'd0, l2_request_valid}, 32'd1);
        chk("t1_type", {30'd0, l2_request_type}, 32'd0);
        chk("t1_addr", {6'd0, l2_request_addr}, 32'h123);
        chk("t1_idx", {30'd0, l2_request_idx}, 32'd2);
        chk("t1_sync", {31'd0, l2_request_sync}, 32'd1);
        #1;
        chk("t1_ack_once", {29'd0, acks}, 32'd0);
        chk("t1_credit", 32'(dut.credit_count), 32'd7);
        tick();
        chk("t1_drain", {31'd0, l2_request_valid}, 32'd0);

        // round robin with all three sources ready
        do_reset();
        dd_dequeue_ready = 1'b1;
        ic_dequeue_ready = 1'b1;
        sq_dequeue_ready = 1'b1;
        dd_dequeue_addr  = 26'h10;
        ic_dequeue_addr  = 26'h20;
        sq_dequeue_addr  = 26'h30;
        dd_dequeue_sync  = 1'b1;
        l2_request_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_ack", {29'd0, acks}, 32'(1 << (i % 3)));
            tick();
            chk("t2_type", {30'd0, l2_request_type}, 32'(i % 3));
            chk("t2_addr", {6'd0, l2_request_addr}, 32'(((i % 3) + 1) * 16));
            chk("t2_sync", {31'd0, l2_request_sync}, 32'((i % 3) == 0));
        end
        chk("t2_credit", 32'(dut.credit_count), 32'd2);

        // credit exhaustion and a single credit return
        do_reset();
        dd_dequeue_ready = 1'b1;
        l2_request_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_ack", {31'd0, dd_dequeue_ack}, 32'(i < 8));
            tick();
        end
        chk("t3_credit0", 32'(dut.credit_count), 32'd0);
        l2_response_valid = 1'b1;
        #1;
        chk("t3_ack_resp_cycle", {31'd0, dd_dequeue_ack}, 32'd0);
        tick();
        l2_response_valid = 1'b0;
        #1;
        chk("t3_ack_after_credit", {31'd0, dd_dequeue_ack}, 32'd1);
        tick();
        #1;
        chk("t3_ack_exhausted", {31'd0, dd_dequeue_ack}, 32'd0);

        // backpressure holds the slot, release allows transfer plus new grant
        do_reset();
        sq_dequeue_ready = 1'b1;
        sq_dequeue_addr  = 26'h2AA;
        sq_dequeue_idx   = 2'd1;
        #1;
        chk("t4_ack_first", {29'd0, acks}, 32'b100);
        tick();
        sq_dequeue_addr = 26'h155;
        sq_dequeue_idx  = 2'd3;
        chk("t4_valid", {31'd0, l2_request_valid}, 32'd1);
        chk("t4_type", {30'd0, l2_request_type}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_ack_held", {29'd0, acks}, 32'd0);
            chk("t4_addr_held", {6'd0, l2_request_addr}, 32'h2AA);
            chk("t4_idx_held", {30'd0, l2_request_idx}, 32'd1);
            chk("t4_valid_held", {31'd0, l2_request_valid}, 32'd1);
            tick();
        end
        l2_request_ready = 1'b1;
        #1;
        chk("t4_ack_release", {29'd0, acks}, 32'b100);
        tick();
        sq_dequeue_ready = 1'b0;
        chk("t4_addr_next", {6'd0, l2_request_addr}, 32'h155);
        chk("t4_idx_next", {30'd0, l2_request_idx}, 32'd3);
        chk("t4_valid_next", {31'd0, l2_request_valid}, 32'd1);

        // grant and response together leave credit unchanged
        do_reset();
        dd_dequeue_ready = 1'b1;
        l2_request_ready = 1'b1;
        repeat (5) tick();
        chk("t5_credit_before", 32'(dut.credit_count), 32'd3);
        l2_response_valid = 1'b1;
        #1;
        chk("t5_ack", {31'd0, dd_dequeue_ack}, 32'd1);
        tick();
        l2_response_valid = 1'b0;
        dd_dequeue_ready  = 1'b0;
        chk("t5_credit_after", 32'(dut.credit_count), 32'd3);

        // asynchronous reset mid-stream, then icache wins the first edge
        do_reset();
        dd_dequeue_ready = 1'b1;
        dd_dequeue_addr  = 26'h777;
        l2_request_ready = 1'b1;
        repeat (3) tick();
        chk("t6_credit_pre", 32'(dut.credit_count), 32'd5);
        chk("t6_valid_pre", {31'd0, l2_request_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid_rst", {31'd0, l2_request_valid}, 32'd0);
        chk("t6_credit_rst", 32'(dut.credit_count), 32'd8);
        chk("t6_acks_rst", {29'd0, acks}, 32'd0);
        chk("t6_addr_rst", {6'd0, l2_request_addr}, 32'd0);
        dd_dequeue_ready = 1'b0;
        ic_dequeue_ready = 1'b1;
        ic_dequeue_addr  = 26'h3ABCDE;
        ic_dequeue_idx   = 2'd1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_ic_ack", {29'd0, acks}, 32'b010);
        tick();
        ic_dequeue_ready = 1'b0;
        chk("t6_ic_valid", {31'd0, l2_request_valid}, 32'd1);
        chk("t6_ic_type", {30'd0, l2_request_type}, 32'd1);
        chk("t6_ic_addr", {6'd0, l2_request_addr}, 32'h3ABCDE);
        chk("t6_ic_sync", {31'd0, l2_request_sync}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
